// File: rtl/rc4_stream_ctrl.sv
// rc4_stream_ctrl
// Sequences one RC4 encryption job at a time. A job request (key, key
// length, message length) starts key scheduling in the RC4 core; once the
// core reports init done, every keystream byte is paired with one input
// byte and the XOR is emitted on a registered valid/ready output stream.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cfg_valid/cfg_ready             job request handshake
//   cfg_key/cfg_key_length/cfg_msg_len  job parameters
//   core_start                      one-cycle start pulse to the core
//   core_key/core_key_length        key held stable for the whole job
//   core_init_done                  core key scheduling finished (pulse)
//   core_ks_valid/_byte/_ready      keystream input stream
//   din_valid/_byte/_ready          data input stream
//   dout_valid/_byte/_last/_ready   result stream, last marks final byte
//   busy                            any state other than IDLE
//   job_done                        pulse when the last byte is accepted
//   cfg_err                         pulse when a request is rejected
module rc4_stream_ctrl #(
  parameter int KEY_BYTES = 4,
  parameter int LEN_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [KEY_BYTES*8-1:0] cfg_key,
  input  logic [7:0]             cfg_key_length,
  input  logic [LEN_W-1:0]       cfg_msg_len,
  output logic                   core_start,
  output logic [KEY_BYTES*8-1:0] core_key,
  output logic [7:0]             core_key_length,
  input  logic                   core_init_done,
  input  logic                   core_ks_valid,
  input  logic [7:0]             core_ks_byte,
  output logic                   core_ks_ready,
  input  logic                   din_valid,
  input  logic [7:0]             din_byte,
  output logic                   din_ready,
  output logic                   dout_valid,
  output logic [7:0]             dout_byte,
  output logic                   dout_last,
  input  logic                   dout_ready,
  output logic                   busy,
  output logic                   job_done,
  output logic                   cfg_err
);

  typedef enum logic [1:0] {IDLE, KSA, STREAM, DRAIN} state_t;

  localparam logic [8:0] KEY_MAX = 9'(KEY_BYTES);

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   remaining_reg;
  logic [7:0]         key_length_reg;
  logic               core_start_reg;
  logic               cfg_err_reg;
  logic               dout_valid_reg;
  logic [7:0]         dout_byte_reg;
  logic               dout_last_reg;

  logic cfg_fire;
  logic cfg_ok;
  logic accept_job;
  logic fire;
  logic out_accept;
  logic last_fire;

  assign cfg_fire   = (state_reg == IDLE) && cfg_valid;
  assign cfg_ok     = (cfg_key_length != 8'd0)
                   && ({1'b0, cfg_key_length} <= KEY_MAX)
                   && (cfg_msg_len != '0);
  assign accept_job = cfg_fire && cfg_ok;

  // Both streams are consumed together, and only when the output register
  // is empty or being emptied in the same cycle.
  assign fire       = (state_reg == STREAM) && din_valid && core_ks_valid
                   && (!dout_valid_reg || dout_ready);
  assign out_accept = dout_valid_reg && dout_ready;
  assign last_fire  = fire && (remaining_reg == LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cfg_ready     = 1'b0;
    busy          = 1'b1;
    din_ready     = 1'b0;
    core_ks_ready = 1'b0;
    job_done      = 1'b0;
    case (state_reg)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (accept_job) state_next = KSA;
      end
      KSA: begin
        if (core_init_done) state_next = STREAM;
      end
      STREAM: begin
        din_ready     = fire;
        core_ks_ready = fire;
        if (last_fire) state_next = DRAIN;
      end
      DRAIN: begin
        job_done = out_accept;
        if (out_accept) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Key is latched per byte lane so each lane is an independent enable.
  for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key_lane
    logic [7:0] key_byte_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        key_byte_reg <= 8'd0;
      end else if (accept_job) begin
        key_byte_reg <= cfg_key[gi*8 +: 8];
      end
    end
    assign core_key[gi*8 +: 8] = key_byte_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_reg  <= '0;
      key_length_reg <= 8'd0;
      core_start_reg <= 1'b0;
      cfg_err_reg    <= 1'b0;
      dout_valid_reg <= 1'b0;
      dout_byte_reg  <= 8'd0;
      dout_last_reg  <= 1'b0;
    end else begin
      core_start_reg <= accept_job;
      cfg_err_reg    <= cfg_fire && !cfg_ok;
      if (accept_job) begin
        key_length_reg <= cfg_key_length;
        remaining_reg  <= cfg_msg_len;
      end
      if (fire) begin
        dout_byte_reg  <= din_byte ^ core_ks_byte;
        dout_valid_reg <= 1'b1;
        dout_last_reg  <= last_fire;
        remaining_reg  <= remaining_reg - LEN_W'(1);
      end else if ((state_reg == STREAM) && dout_ready) begin
        dout_valid_reg <= 1'b0;
      end else if ((state_reg == DRAIN) && out_accept) begin
        dout_valid_reg <= 1'b0;
        dout_last_reg  <= 1'b0;
      end
    end
  end

  assign core_start      = core_start_reg;
  assign core_key_length = key_length_reg;
  assign cfg_err         = cfg_err_reg;
  assign dout_valid      = dout_valid_reg;
  assign dout_byte       = dout_byte_reg;
  assign dout_last       = dout_last_reg;

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// tb_rc4_stream_ctrl
// Directed bench for rc4_stream_ctrl: the bench plays the RC4 core and the
// host, and checks the result stream against hand-computed vectors.
module tb_rc4_stream_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_key;
  logic [7:0]  cfg_key_length;
  logic [15:0] cfg_msg_len;
  logic        core_start;
  logic [31:0] core_key;
  logic [7:0]  core_key_length;
  logic        core_init_done;
  logic        core_ks_valid;
  logic [7:0]  core_ks_byte;
  logic        core_ks_ready;
  logic        din_valid;
  logic [7:0]  din_byte;
  logic        din_ready;
  logic        dout_valid;
  logic [7:0]  dout_byte;
  logic        dout_last;
  logic        dout_ready;
  logic        busy;
  logic        job_done;
  logic        cfg_err;

  rc4_stream_ctrl #(.KEY_BYTES(4), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key),
    .cfg_key_length(cfg_key_length), .cfg_msg_len(cfg_msg_len),
    .core_start(core_start), .core_key(core_key), .core_key_length(core_key_length),
    .core_init_done(core_init_done), .core_ks_valid(core_ks_valid),
    .core_ks_byte(core_ks_byte), .core_ks_ready(core_ks_ready),
    .din_valid(din_valid), .din_byte(din_byte), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout_byte(dout_byte), .dout_last(dout_last),
    .dout_ready(dout_ready), .busy(busy), .job_done(job_done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] ks;
    logic [7:0] exp_out;
  } svec_t;

  typedef struct {
    logic [7:0]  klen;
    logic [15:0] mlen;
  } cvec_t;

  svec_t      basic_tbl [4];
  cvec_t      bad_tbl [3];
  logic [7:0] din_arr [0:63];
  logic [7:0] ks_arr  [0:63];
  logic [7:0] exp_arr [0:63];

  int tests_run = 0;
  int tests_failed = 0;
  int start_cnt = 0;

  always @(negedge clk) if (core_start) start_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue a request starting from an IDLE cycle and check the start pulse.
  task automatic request(input logic [31:0] key, input logic [7:0] kl, input logic [15:0] ml);
    cfg_valid = 1'b1; cfg_key = key; cfg_key_length = kl; cfg_msg_len = ml;
    #1;
    check("req_cfg_ready", cfg_ready, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("req_core_start", core_start, 1);
    check("req_busy", busy, 1);
    check("req_cfg_ready_low", cfg_ready, 0);
    check("req_cfg_err", cfg_err, 0);
    check("req_core_key", core_key, key);
    check("req_key_length", core_key_length, kl);
    $display("[TB] request key %08h len %0d msg %0d accepted", key, kl, ml);
  endtask

  // KSA with both streams offered, then the stream phase until n outputs.
  task automatic body(input int n, input bit stall);
    int         in_idx = 0;
    int         out_idx = 0;
    int         cyc = 0;
    bit         held_v = 0;
    logic [7:0] held_b = 8'd0;
    bit         fire_s;
    din_valid = 1'b1; core_ks_valid = 1'b1; dout_ready = 1'b1;
    din_byte = din_arr[0]; core_ks_byte = ks_arr[0];
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ksa_gate", {din_ready, core_ks_ready}, 0);
      @(posedge clk); #1;
      check("start_once", core_start, 0);
    end
    core_init_done = 1'b1;
    #1;
    check("ksa_gate_init", {din_ready, core_ks_ready}, 0);
    check("ksa_no_dout", dout_valid, 0);
    @(posedge clk); #1;
    core_init_done = 1'b0;
    while (out_idx < n && cyc < 2000) begin
      if (stall) begin
        din_valid     = (in_idx < n) && ($urandom_range(3) != 0);
        core_ks_valid = ($urandom_range(3) != 0);
        dout_ready    = ($urandom_range(2) != 0);
      end else begin
        din_valid     = (in_idx < n);
        core_ks_valid = 1'b1;
        dout_ready    = 1'b1;
      end
      if (in_idx < n) begin
        din_byte = din_arr[in_idx]; core_ks_byte = ks_arr[in_idx];
      end
      #1;
      if (held_v) begin
        check("hold_valid", dout_valid, 1);
        check("hold_byte", dout_byte, held_b);
      end
      check("ready_pair", din_ready, core_ks_ready);
      check("fire_cond", din_ready, din_valid & core_ks_valid & (!dout_valid | dout_ready));
      fire_s = din_ready;
      held_v = dout_valid & !dout_ready;
      held_b = dout_byte;
      if (dout_valid && dout_ready) begin
        check("dout_byte", dout_byte, exp_arr[out_idx]);
        check("dout_last", dout_last, (out_idx == n - 1));
        check("job_done", job_done, (out_idx == n - 1));
        $display("[TB] out %0d byte %02h last %0d", out_idx, dout_byte, dout_last);
        out_idx++;
      end else begin
        check("job_done_idle", job_done, 0);
      end
      if (fire_s) in_idx++;
      @(posedge clk); #1;
      cyc++;
    end
    din_valid = 1'b0; core_ks_valid = 1'b0;
    if (out_idx < n) begin
      tests_run++; tests_failed++;
      $display("FAIL stream_timeout: got %0d outputs expected %0d", out_idx, n);
    end
    if (!stall) check("throughput_cycles", cyc, n + 1);
    check("post_busy", busy, 0);
    check("post_cfg_ready", cfg_ready, 1);
    check("post_dout_valid", dout_valid, 0);
    check("post_dout_last", dout_last, 0);
  endtask

  initial begin
    int s0;
    basic_tbl[0] = '{din: 8'h01, ks: 8'hAA, exp_out: 8'hAB};
    basic_tbl[1] = '{din: 8'h02, ks: 8'h55, exp_out: 8'h57};
    basic_tbl[2] = '{din: 8'h03, ks: 8'h0F, exp_out: 8'h0C};
    basic_tbl[3] = '{din: 8'h04, ks: 8'hF0, exp_out: 8'hF4};
    bad_tbl[0]   = '{klen: 8'd0, mlen: 16'd4};
    bad_tbl[1]   = '{klen: 8'd5, mlen: 16'd4};
    bad_tbl[2]   = '{klen: 8'd4, mlen: 16'd0};

    rst_n = 1'b1; cfg_valid = 1'b0; cfg_key = '0; cfg_key_length = '0; cfg_msg_len = '0;
    core_init_done = 1'b0; core_ks_valid = 1'b0; core_ks_byte = '0;
    din_valid = 1'b0; din_byte = '0; dout_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_outputs", {core_start, core_ks_ready, din_ready, dout_valid,
                          dout_last, busy, job_done, cfg_err}, 0);
    check("rst_dout_byte", dout_byte, 0);
    check("rst_core_key", core_key, 0);
    check("rst_key_length", core_key_length, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Invalid requests: each rejected with a single cfg_err pulse.
    s0 = start_cnt;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_key = 32'h11223344;
      cfg_key_length = bad_tbl[i].klen; cfg_msg_len = bad_tbl[i].mlen;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      check("bad_cfg_err", cfg_err, 1);
      check("bad_core_start", core_start, 0);
      check("bad_busy", busy, 0);
      check("bad_key_unlatched", core_key, 0);
      @(posedge clk); #1;
      check("bad_cfg_err_pulse", cfg_err, 0);
      $display("[TB] reject klen %0d msg %0d", bad_tbl[i].klen, bad_tbl[i].mlen);
    end
    check("bad_start_count", start_cnt, s0);

    // Basic job at full throughput.
    for (int i = 0; i < 4; i++) begin
      din_arr[i] = basic_tbl[i].din; ks_arr[i] = basic_tbl[i].ks;
      exp_arr[i] = basic_tbl[i].exp_out;
    end
    s0 = start_cnt;
    request(32'h40302010, 8'd4, 16'd4);
    body(4, 1'b0);
    check("basic_start_count", start_cnt, s0 + 1);

    // 64-byte job with random stalls and backpressure.
    for (int i = 0; i < 64; i++) begin
      din_arr[i] = 8'($urandom); ks_arr[i] = 8'($urandom);
      exp_arr[i] = din_arr[i] ^ ks_arr[i];
    end
    s0 = start_cnt;
    request(32'hA5A5_0102, 8'd3, 16'd64);
    body(64, 1'b1);
    check("stall_start_count", start_cnt, s0 + 1);

    // Back-to-back: second request pending throughout job 1.
    din_arr[0] = 8'h10; ks_arr[0] = 8'h01; exp_arr[0] = 8'h11;
    din_arr[1] = 8'h20; ks_arr[1] = 8'h02; exp_arr[1] = 8'h22;
    s0 = start_cnt;
    request(32'h01020304, 8'd4, 16'd2);
    cfg_valid = 1'b1; cfg_key = 32'hDEADBEEF; cfg_key_length = 8'd2; cfg_msg_len = 16'd1;
    body(2, 1'b0);
    check("b2b_ignored_while_busy", start_cnt, s0 + 1);
    check("b2b_key_job1", core_key, 32'h01020304);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("b2b_core_start", core_start, 1);
    check("b2b_core_key", core_key, 32'hDEADBEEF);
    check("b2b_key_length", core_key_length, 2);
    din_arr[0] = 8'h5A; ks_arr[0] = 8'hFF; exp_arr[0] = 8'hA5;
    body(1, 1'b0);
    check("b2b_start_count", start_cnt, s0 + 2);

    // Reset in the middle of a stream.
    din_arr[0] = 8'h01; ks_arr[0] = 8'h02;
    din_arr[1] = 8'h03; ks_arr[1] = 8'h04;
    request(32'hCAFEF00D, 8'd4, 16'd8);
    core_init_done = 1'b1;
    @(posedge clk); #1;
    core_init_done = 1'b0;
    din_valid = 1'b1; core_ks_valid = 1'b1; dout_ready = 1'b0;
    din_byte = din_arr[0]; core_ks_byte = ks_arr[0];
    @(posedge clk); #1;
    check("mid_dout_valid", dout_valid, 1);
    check("mid_dout_byte", dout_byte, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cfg_ready", cfg_ready, 1);
    check("arst_outputs", {core_start, core_ks_ready, din_ready, dout_valid,
                           dout_last, busy, job_done, cfg_err}, 0);
    check("arst_dout_byte", dout_byte, 0);
    check("arst_core_key", core_key, 0);
    s0 = start_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_start", core_start, 0);
      check("post_rst_ready", din_ready, 0);
    end
    check("post_rst_cfg_ready", cfg_ready, 1);
    check("post_rst_start_count", start_cnt, s0);
    din_valid = 1'b0; core_ks_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rc4_stream_ctrl.md
# rc4_stream_ctrl

Sequencing controller for the RC4 keystream core. It accepts one encryption job at a time: key, key length and message length. It drives the core's key-scheduling start, waits for key scheduling to complete, and then pairs each keystream byte with one input data byte. The XOR result is emitted on a registered valid/ready output stream. It sits between the host/DMA job interface and the RC4 core, and is the only block that issues `start` to the core.

## Interface
- `KEY_BYTES`, default 4: maximum key length in bytes; the key bus is `KEY_BYTES*8` bits, with byte 0 in bits [7:0].
- `LEN_W`, default 16: width of the message-length field.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_valid`  in  1  job request.
- `cfg_ready`  out  1  job accepted when `cfg_valid & cfg_ready`.
- `cfg_key`  in  KEY_BYTES*8  key bytes.
- `cfg_key_length`  in  8  key length in bytes.
- `cfg_msg_len`  in  LEN_W  number of data bytes in the job.
- `core_start`  out  1  one-cycle start pulse to the RC4 core.
- `core_key`  out  KEY_BYTES*8  latched key, held stable for the whole job.
- `core_key_length`  out  8  latched key length, held stable for the whole job.
- `core_init_done`  in  1  core has finished key scheduling; single-cycle pulse.
- `core_ks_valid`  in  1  keystream byte available.
- `core_ks_byte`  in  8  keystream byte.
- `core_ks_ready`  out  1  keystream byte consumed this cycle.
- `din_valid`, `din_byte`  in  1, 8  plaintext/ciphertext input.
- `din_ready`  out  1  input byte consumed this cycle.
- `dout_valid`, `dout_byte`, `dout_last`  out  1, 8, 1  result stream; `dout_last` marks the final byte of the job.
- `dout_ready`  in  1  downstream accepts.
- `busy`  out  1  high in any state other than IDLE.
- `job_done`  out  1  one-cycle pulse when the last byte leaves `dout`.
- `cfg_err`  out  1  one-cycle pulse when a request is rejected.

## Operation
- State machine states: IDLE, KSA, STREAM, DRAIN.
- **IDLE**
  - `cfg_ready`=1.
  - On the handshake, the request is valid if `1 <= cfg_key_length <= KEY_BYTES` and `cfg_msg_len != 0`. In that case:
    - latch key, key length and message length (into `remaining`);
    - go to KSA;
    - pulse `core_start` in the next cycle.
  - Otherwise pulse `cfg_err` in the next cycle and stay in IDLE. Nothing is latched and no `core_start` is issued.
- **KSA**
  - `cfg_ready`=0. Wait for `core_init_done`, then go to STREAM.
  - `core_ks_valid` is ignored in this state.
- **STREAM**
  - Transfer condition: `fire = din_valid & core_ks_valid & (!dout_valid | dout_ready)`.
  - On `fire`:
    - `din_ready` and `core_ks_ready` are both 1 in the same cycle;
    - `dout_byte` <= `din_byte ^ core_ks_byte`;
    - `dout_valid` <= 1;
    - `remaining` decrements by 1.
  - Both input streams are always consumed together; neither is ever consumed alone.
  - When `fire` occurs with `remaining == 1`:
    - `dout_last` <= 1;
    - go to DRAIN.
  - If `dout_ready` is high with no `fire`, `dout_valid` <= 0.
- **DRAIN**
  - No consumption.
  - When `dout_valid & dout_ready`: clear `dout_valid` and `dout_last`, pulse `job_done` in the same cycle, go to IDLE.
- `dout_*` is a single output register. Holding the output at full throughput requires `dout_ready` to be high in the same cycle as `fire`.
- `din_ready` and `core_ks_ready` are combinational from the current state, the input valids and `dout_ready`. They are 0 outside STREAM.
- The counter is `LEN_W` bits wide. It never wraps, because a zero length is rejected.
- Reset mid-job returns to IDLE immediately. All outputs go to their reset values. The core is not re-started until a new request arrives.

## Timing
- Reset values: `cfg_ready`=1; `core_start`, `core_ks_ready`, `din_ready`, `dout_valid`, `dout_last`, `busy`, `job_done`, `cfg_err` all 0; `dout_byte`, `core_key` and `core_key_length` all 0.
- Request handshake at cycle T:
  - `core_start`=1 and `busy`=1 at T+1;
  - `core_start`=0 from T+2 onward.
- `core_init_done` at cycle U gives state STREAM at U+1. The earliest `fire` is at U+1.
- Latency from `fire` to `dout_valid`: 1 cycle.
- Throughput: one byte per cycle when all valids and `dout_ready` are high.
- `job_done` coincides with the acceptance cycle of the `dout_last` byte. `cfg_ready` returns to 1 in the following cycle.
- `cfg_valid` is ignored while `busy`.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_n`=0 mid-STREAM.
  - Response: all outputs return to their reset values asynchronously; after release, `cfg_ready`=1 and `core_start` stays 0.
- **Basic job:**
  - Stimulus: key 32'h40302010, length 4, `msg_len` 4. Core model returns keystream 8'hAA,8'h55,8'h0F,8'hF0. Data in is 8'h01,8'h02,8'h03,8'h04. All valids and ready are held high.
  - Response: `dout` = 8'hAB,8'h57,8'h0C,8'hF4 on consecutive cycles; `dout_last` on the 4th byte; `job_done` on the 4th acceptance; exactly one `core_start` pulse.
- **Invalid request:**
  - Stimulus: `cfg_key_length`=0; then `cfg_key_length`=5; then `cfg_msg_len`=0.
  - Response: each gives a `cfg_err` pulse, no `core_start`, and `busy` stays 0.
- **Backpressure and stalls:**
  - Stimulus: toggle `dout_ready`, `din_valid` and `core_ks_valid` randomly over a 64-byte job.
  - Response: 64 outputs, in order, each correct; `din_ready` always equals `core_ks_ready`; `dout_byte` holds stable while `dout_valid & !dout_ready`.
- **KSA gating:**
  - Stimulus: `core_ks_valid`=1 and `din_valid`=1 during KSA.
  - Response: no consumption until the cycle after `core_init_done`.
- **Back-to-back jobs:**
  - Stimulus: a second request held pending during job 1, with `msg_len` 1.
  - Response: accepted in the cycle after `job_done`; a fresh `core_start`; the new key appears on `core_key`.
